// File: rtl/conv_pkg.sv
// Shared types and constants for the 3x3 convolution line-buffer sequencer.
package conv_pkg;

    localparam int unsigned KERNEL_ROWS = 3;
    localparam int unsigned NUM_LINEBUF = 3;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FILL      = 3'd1,
        ST_SWEEP     = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_LOAD      = 3'd4,
        ST_DONE      = 3'd5
    } state_e;

    // One-hot select of a line buffer from its index.
    function automatic logic [NUM_LINEBUF-1:0] buf_onehot(input logic [1:0] idx);
        return NUM_LINEBUF'(1) << idx;
    endfunction

endpackage

// File: rtl/conv_row_sequencer_wrap_counter.sv
// Modulo-(MAX+1) up counter with synchronous clear and a wrap pulse on the terminal count.
module wrap_counter #(
    parameter int unsigned MAX = 7,
    parameter int unsigned W   = $clog2(MAX + 1)
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_en,
    input  logic         i_clear,
    output logic [W-1:0] o_count,
    output logic         o_wrap
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;
    logic         at_max;

    assign at_max = (count_q == W'(MAX));

    always_comb begin
        count_d = count_q;
        if (i_clear) begin
            count_d = '0;
        end else if (i_en) begin
            count_d = at_max ? '0 : count_q + W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_count = count_q;
    assign o_wrap  = i_en && !i_clear && at_max;

endmodule

// File: rtl/conv_row_sequencer.sv
// Control sequencer for the 3-row line buffers feeding the 3x3 convolution datapath:
// fill, sweep, wait for drain, then rotate the oldest buffer for the next row.
module conv_row_sequencer
    import conv_pkg::*;
#(
    parameter int unsigned IMG_W  = 8,
    parameter int unsigned IMG_H  = 8,
    parameter int unsigned ADDR_W = $clog2(IMG_W)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_pix_valid,
    output logic              o_pix_ready,
    output logic [2:0]        o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic              o_rd_en,
    output logic [ADDR_W-1:0] o_rd_addr,
    output logic [1:0]        o_row_sel,
    output logic              o_compute_conv,
    output logic              o_win_valid,
    input  logic              i_conv_done,
    output logic              o_busy,
    output logic              o_frame_done
);

    localparam int unsigned OUT_ROWS = IMG_H - (KERNEL_ROWS - 1);
    localparam int unsigned ROW_W    = $clog2(OUT_ROWS + 1);
    localparam int unsigned PTR_W    = $clog2(NUM_LINEBUF);

    if (IMG_W < 3 || IMG_H < 3) begin : g_param_check
        $error("conv_row_sequencer: IMG_W and IMG_H must both be >= 3");
    end

    state_e            state_q, state_d;
    logic [ROW_W-1:0]  out_row_q, out_row_d, out_row_inc;
    logic              win_valid_q, win_valid_d;

    logic [ADDR_W-1:0] wr_col, rd_col;
    logic [PTR_W-1:0]  wr_ptr;
    logic              wr_col_wrap, rd_col_wrap, wr_ptr_wrap;
    logic              in_write, in_sweep, accept;

    assign in_write    = (state_q == ST_FILL) || (state_q == ST_LOAD);
    assign in_sweep    = (state_q == ST_SWEEP);
    assign accept      = in_write && i_pix_valid;
    assign out_row_inc = out_row_q + ROW_W'(1);

    wrap_counter #(.MAX(IMG_W - 1), .W(ADDR_W)) u_wr_col (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_en    (accept),
        .i_clear (state_q == ST_IDLE),
        .o_count (wr_col),
        .o_wrap  (wr_col_wrap)
    );

    wrap_counter #(.MAX(IMG_W - 1), .W(ADDR_W)) u_rd_col (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_en    (in_sweep),
        .i_clear (state_q == ST_IDLE),
        .o_count (rd_col),
        .o_wrap  (rd_col_wrap)
    );

    // Write pointer doubles as the index of the oldest row once a row completes.
    wrap_counter #(.MAX(NUM_LINEBUF - 1), .W(PTR_W)) u_wr_ptr (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_en    (wr_col_wrap),
        .i_clear (state_q == ST_DONE),
        .o_count (wr_ptr),
        .o_wrap  (wr_ptr_wrap)
    );

    always_comb begin
        state_d     = state_q;
        out_row_d   = out_row_q;
        win_valid_d = in_sweep && (rd_col >= ADDR_W'(2));
        case (state_q)
            ST_IDLE:      if (i_start) state_d = ST_FILL;
            // FILL ends once the third buffer completes, i.e. the pointer wraps.
            ST_FILL:      if (wr_ptr_wrap) state_d = ST_SWEEP;
            ST_LOAD:      if (wr_col_wrap) state_d = ST_SWEEP;
            ST_SWEEP:     if (rd_col_wrap) state_d = ST_WAIT_DONE;
            ST_WAIT_DONE: begin
                if (i_conv_done) begin
                    out_row_d = out_row_inc;
                    state_d   = (out_row_inc == ROW_W'(OUT_ROWS)) ? ST_DONE : ST_LOAD;
                end
            end
            ST_DONE: begin
                out_row_d = '0;
                state_d   = ST_IDLE;
            end
            default:      state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            out_row_q   <= '0;
            win_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_row_q   <= out_row_d;
            win_valid_q <= win_valid_d;
        end
    end

    assign o_pix_ready    = in_write;
    assign o_wr_en        = buf_onehot(wr_ptr) & {NUM_LINEBUF{accept}};
    assign o_wr_addr      = wr_col;
    assign o_rd_en        = in_sweep;
    assign o_rd_addr      = rd_col;
    assign o_row_sel      = wr_ptr;
    assign o_compute_conv = in_sweep;
    assign o_win_valid    = win_valid_q;
    assign o_busy         = (state_q != ST_IDLE);
    assign o_frame_done   = (state_q == ST_DONE);

endmodule
